wb_stage: RTL and testbench

//  Write-back stage of the RV32I pipeline; the writer side of the regfile port that decode reads.

---
 rtl/wb_stage_pkg.sv | 33 +++
 rtl/wb_load_align.sv | 33 +++
 rtl/wb_stage.sv | 168 ++++++++++++++++
 tb/tb_wb_stage.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_stage_pkg.sv
// Shared types for the RV32I write-back stage.
//   regfilemux_sel_t   : write-data source select carried in the control word
//   rv32i_control_word : control bits the write-back stage consumes
//   wb_state_t         : load-response wait FSM state
package wb_stage_pkg;

    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned INSTRET_W  = 64;

    typedef enum logic [3:0] {
        RF_ALU_OUT  = 4'd0,
        RF_BR_EN    = 4'd1,
        RF_U_IMM    = 4'd2,
        RF_LW       = 4'd3,
        RF_PC_PLUS4 = 4'd4,
        RF_LB       = 4'd5,
        RF_LBU      = 4'd6,
        RF_LH       = 4'd7,
        RF_LHU      = 4'd8
    } regfilemux_sel_t;

    typedef struct packed {
        logic            load_regfile;
        logic            mem_read;
        regfilemux_sel_t regfilemux_sel;
    } rv32i_control_word;

    typedef enum logic {
        WB_IDLE = 1'b0,
        WB_WAIT = 1'b1
    } wb_state_t;

endpackage

// File: rtl/wb_load_align.sv
// Combinational load alignment: picks the addressed byte/half of the
// memory read word and sign- or zero-extends it; full-word loads pass through.
//   rdata_i  : data-memory read word
//   offset_i : byte offset within the word (bit 0 ignored for halves)
//   sel_i    : regfilemux select of the load
//   data_c   : aligned, extended word
module wb_load_align
    import wb_stage_pkg::*;
#(
    parameter int unsigned width = 32
) (
    input  logic [width-1:0] rdata_i,
    input  logic [1:0]       offset_i,
    input  regfilemux_sel_t  sel_i,
    output logic [width-1:0] data_c
);

    logic [7:0]  byte_c;
    logic [15:0] half_c;

    always_comb begin
        byte_c = rdata_i[{offset_i, 3'b000} +: 8];
        half_c = rdata_i[{offset_i[1], 4'b0000} +: 16];
        case (sel_i)
            RF_LB:   data_c = {{(width-8){byte_c[7]}}, byte_c};
            RF_LBU:  data_c = {{(width-8){1'b0}}, byte_c};
            RF_LH:   data_c = {{(width-16){half_c[15]}}, half_c};
            RF_LHU:  data_c = {{(width-16){1'b0}}, half_c};
            default: data_c = rdata_i;
        endcase
    end

endmodule

// File: rtl/wb_stage.sv
// RV32I write-back stage. Registers the MEM/WB bundle, holds it while a load
// waits for its data-memory response, and drives the regfile write port.
// Optional feature macro: WB_INSTRET_EN (64-bit retired-instruction counter).
//   clk, rst (async, active-low)
//   WB_valid_i/WB_flush_i     : bundle valid / capture a bubble instead
//   WB_ctrl_word_i .. WB_pc_out_i : MEM/WB bundle payload
//   WB_dmem_resp_i/_rdata_i   : data-memory read response
//   WB_load_regfile_o, WB_rd_wr_o, WB_wr_data_o : regfile write port
//   WB_stall_o                : freeze upstream while a load is outstanding
//   WB_instret_o              : retired-instruction count (0 when disabled)
module wb_stage
    import wb_stage_pkg::*;
#(
    parameter int unsigned width = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  WB_valid_i,
    input  logic                  WB_flush_i,
    input  rv32i_control_word     WB_ctrl_word_i,
    input  logic [REG_ADDR_W-1:0] WB_rd_i,
    input  logic [width-1:0]      WB_alu_out_i,
    input  logic                  WB_br_en_i,
    input  logic [width-1:0]      WB_u_imm_i,
    input  logic [width-1:0]      WB_pc_out_i,
    input  logic                  WB_dmem_resp_i,
    input  logic [width-1:0]      WB_dmem_rdata_i,
    output logic                  WB_load_regfile_o,
    output logic [REG_ADDR_W-1:0] WB_rd_wr_o,
    output logic [width-1:0]      WB_wr_data_o,
    output logic                  WB_stall_o,
    output logic [INSTRET_W-1:0]  WB_instret_o
);

    logic                  valid_q,   valid_d;
    rv32i_control_word     ctrl_q,    ctrl_d;
    logic [REG_ADDR_W-1:0] rd_q,      rd_d;
    logic [width-1:0]      alu_out_q, alu_out_d;
    logic                  br_en_q,   br_en_d;
    logic [width-1:0]      u_imm_q,   u_imm_d;
    logic [width-1:0]      pc_q,      pc_d;
    wb_state_t             state_q,   state_d;

    logic                  stall_c;
    logic                  commit_c;
    logic                  load_regfile_c;
    logic [width-1:0]      load_data_c;
    logic [width-1:0]      wr_data_c;

    // FSM state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= WB_IDLE;
        else      state_q <= state_d;
    end

    // FSM next state: track an outstanding load response
    always_comb begin
        state_d = state_q;
        case (state_q)
            WB_IDLE: if (valid_q && ctrl_q.mem_read && !WB_dmem_resp_i) state_d = WB_WAIT;
            WB_WAIT: if (WB_dmem_resp_i)                                 state_d = WB_IDLE;
            default: state_d = WB_IDLE;
        endcase
    end

    // FSM outputs: stall and commit depend only on the registered bundle and resp
    always_comb begin
        stall_c        = 1'b0;
        commit_c       = 1'b0;
        load_regfile_c = 1'b0;
        if (valid_q) begin
            stall_c  = ctrl_q.mem_read && !WB_dmem_resp_i;
            commit_c = !ctrl_q.mem_read || WB_dmem_resp_i;
        end
        load_regfile_c = commit_c && ctrl_q.load_regfile && (rd_q != '0);
    end

    // Stage register next value: hold while stalled, a flush captures a bubble
    always_comb begin
        valid_d   = valid_q;
        ctrl_d    = ctrl_q;
        rd_d      = rd_q;
        alu_out_d = alu_out_q;
        br_en_d   = br_en_q;
        u_imm_d   = u_imm_q;
        pc_d      = pc_q;
        if (!stall_c) begin
            valid_d   = WB_valid_i && !WB_flush_i;
            ctrl_d    = WB_ctrl_word_i;
            rd_d      = WB_rd_i;
            alu_out_d = WB_alu_out_i;
            br_en_d   = WB_br_en_i;
            u_imm_d   = WB_u_imm_i;
            pc_d      = WB_pc_out_i;
        end
    end

    // Stage register; cleared fields make every write-port output read zero in reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q   <= 1'b0;
            ctrl_q    <= '0;
            rd_q      <= '0;
            alu_out_q <= '0;
            br_en_q   <= 1'b0;
            u_imm_q   <= '0;
            pc_q      <= '0;
        end else begin
            valid_q   <= valid_d;
            ctrl_q    <= ctrl_d;
            rd_q      <= rd_d;
            alu_out_q <= alu_out_d;
            br_en_q   <= br_en_d;
            u_imm_q   <= u_imm_d;
            pc_q      <= pc_d;
        end
    end

    wb_load_align #(
        .width (width)
    ) u_load_align (
        .rdata_i  (WB_dmem_rdata_i),
        .offset_i (alu_out_q[1:0]),
        .sel_i    (ctrl_q.regfilemux_sel),
        .data_c   (load_data_c)
    );

    // Write-data select
    always_comb begin
        case (ctrl_q.regfilemux_sel)
            RF_ALU_OUT:  wr_data_c = alu_out_q;
            RF_BR_EN:    wr_data_c = {{(width-1){1'b0}}, br_en_q};
            RF_U_IMM:    wr_data_c = u_imm_q;
            RF_PC_PLUS4: wr_data_c = pc_q + width'(4);
            RF_LW,
            RF_LB,
            RF_LBU,
            RF_LH,
            RF_LHU:      wr_data_c = load_data_c;
            default:     wr_data_c = alu_out_q;
        endcase
    end

`ifdef WB_INSTRET_EN
    logic [INSTRET_W-1:0] instret_q, instret_d;

    // Counts every commit, regardless of rd or whether it writes
    always_comb begin
        instret_d = instret_q;
        if (commit_c) instret_d = instret_q + INSTRET_W'(1);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) instret_q <= '0;
        else      instret_q <= instret_d;
    end

    assign WB_instret_o = instret_q;
`else
    assign WB_instret_o = '0;
`endif

    assign WB_load_regfile_o = load_regfile_c;
    assign WB_rd_wr_o        = rd_q;
    assign WB_wr_data_o      = wr_data_c;
    assign WB_stall_o        = stall_c;

endmodule

// File: tb/tb_wb_stage.sv
// Self-checking bench for wb_stage: directed scenarios with literal
// expectations followed by randomized traffic checked every cycle against
// an instruction-level model of the write-back stage.
module tb_wb_stage;
    import wb_stage_pkg::*;

    logic              clk = 1'b0;
    logic              rst;
    logic              valid_i, flush_i, br_en_i, resp_i;
    rv32i_control_word ctrl_i;
    logic [4:0]        rd_i;
    logic [31:0]       alu_i, uimm_i, pc_i, rdata_i;
    logic              load_regfile_o, stall_o;
    logic [4:0]        rd_wr_o;
    logic [31:0]       wr_data_o;
    logic [63:0]       instret_o;

    int checks = 0;
    int errors = 0;

    wb_stage #(.width(32)) dut (
        .clk               (clk),
        .rst               (rst),
        .WB_valid_i        (valid_i),
        .WB_flush_i        (flush_i),
        .WB_ctrl_word_i    (ctrl_i),
        .WB_rd_i           (rd_i),
        .WB_alu_out_i      (alu_i),
        .WB_br_en_i        (br_en_i),
        .WB_u_imm_i        (uimm_i),
        .WB_pc_out_i       (pc_i),
        .WB_dmem_resp_i    (resp_i),
        .WB_dmem_rdata_i   (rdata_i),
        .WB_load_regfile_o (load_regfile_o),
        .WB_rd_wr_o        (rd_wr_o),
        .WB_wr_data_o      (wr_data_o),
        .WB_stall_o        (stall_o),
        .WB_instret_o      (instret_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    function automatic rv32i_control_word mk_ctrl(input logic lr, input logic mr, input regfilemux_sel_t sel);
        rv32i_control_word c;
        c.load_regfile   = lr;
        c.mem_read       = mr;
        c.regfilemux_sel = sel;
        return c;
    endfunction

    // Instruction-level model: the instruction currently held in write-back
    logic              m_valid;
    rv32i_control_word m_ctrl;
    logic [4:0]        m_rd;
    logic [31:0]       m_alu, m_uimm, m_pc;
    logic              m_br;
    logic [63:0]       m_instret;

    function automatic logic [31:0] model_wdata(input regfilemux_sel_t sel, input logic [31:0] alu,
                                                input logic br, input logic [31:0] uimm,
                                                input logic [31:0] pc, input logic [31:0] rdata);
        logic [31:0] sh_b, sh_h, b, h;
        sh_b = (alu % 32'd4) * 32'd8;
        sh_h = ((alu % 32'd4) / 32'd2) * 32'd16;
        b = (rdata >> sh_b) & 32'hFF;
        h = (rdata >> sh_h) & 32'hFFFF;
        case (sel)
            RF_ALU_OUT:  return alu;
            RF_BR_EN:    return br ? 32'd1 : 32'd0;
            RF_U_IMM:    return uimm;
            RF_PC_PLUS4: return pc + 32'd4;
            RF_LW:       return rdata;
            RF_LB:       return (b >= 32'd128) ? b - 32'd256 : b;
            RF_LBU:      return b;
            RF_LH:       return (h >= 32'd32768) ? h - 32'd65536 : h;
            RF_LHU:      return h;
            default:     return alu;
        endcase
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_valid   = 1'b0;
            m_ctrl    = '0;
            m_rd      = '0;
            m_alu     = '0;
            m_uimm    = '0;
            m_pc      = '0;
            m_br      = 1'b0;
            m_instret = '0;
        end else begin
            if (m_valid && (!m_ctrl.mem_read || resp_i)) m_instret = m_instret + 64'd1;
            if (!(m_valid && m_ctrl.mem_read && !resp_i)) begin
                m_valid = valid_i && !flush_i;
                m_ctrl  = ctrl_i;
                m_rd    = rd_i;
                m_alu   = alu_i;
                m_uimm  = uimm_i;
                m_pc    = pc_i;
                m_br    = br_en_i;
            end
        end
    end

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        logic e_commit, e_stall, e_lr;
        logic [63:0] e_ir;
        if (rst) begin
            e_stall  = m_valid && m_ctrl.mem_read && !resp_i;
            e_commit = m_valid && (!m_ctrl.mem_read || resp_i);
            e_lr     = e_commit && m_ctrl.load_regfile && (m_rd != 5'd0);
`ifdef WB_INSTRET_EN
            e_ir = m_instret;
`else
            e_ir = 64'd0;
`endif
            chk("model_load_regfile", 64'(load_regfile_o), 64'(e_lr));
            chk("model_stall", 64'(stall_o), 64'(e_stall));
            chk("model_rd_wr", 64'(rd_wr_o), 64'(m_rd));
            if (e_lr)
                chk("model_wr_data", 64'(wr_data_o),
                    64'(model_wdata(m_ctrl.regfilemux_sel, m_alu, m_br, m_uimm, m_pc, rdata_i)));
            chk("model_instret", instret_o, e_ir);
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        valid_i = 1'b0; flush_i = 1'b0; ctrl_i = '0; rd_i = '0; alu_i = '0;
        br_en_i = 1'b0; uimm_i = '0; pc_i = '0; resp_i = 1'b0; rdata_i = '0;
    endtask

    initial begin
        logic [63:0] ir_before;
        logic [63:0] ir_step;
        regfilemux_sel_t rsel;
        rst = 1'b0;
        idle_inputs();
`ifdef WB_INSTRET_EN
        ir_step = 64'd1;
`else
        ir_step = 64'd0;
`endif
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_load_regfile", 64'(load_regfile_o), 64'd0);
        chk("reset_stall", 64'(stall_o), 64'd0);
        chk("reset_rd_wr", 64'(rd_wr_o), 64'd0);
        chk("reset_wr_data", 64'(wr_data_o), 64'd0);
        chk("reset_instret", instret_o, 64'd0);
        next_cycle();
        rst = 1'b1;

        // ADDI x5
        next_cycle();
        valid_i = 1'b1; ctrl_i = mk_ctrl(1'b1, 1'b0, RF_ALU_OUT); rd_i = 5'd5; alu_i = 32'h0000_0123;
        next_cycle();
        valid_i = 1'b0;
        @(negedge clk);
        chk("addi_load_regfile", 64'(load_regfile_o), 64'd1);
        chk("addi_rd_wr", 64'(rd_wr_o), 64'd5);
        chk("addi_wr_data", 64'(wr_data_o), 64'h123);
        chk("addi_stall", 64'(stall_o), 64'd0);

        // LB x7, offset 3, response two cycles late
        next_cycle();
        valid_i = 1'b1; ctrl_i = mk_ctrl(1'b1, 1'b1, RF_LB); rd_i = 5'd7; alu_i = 32'h0000_1003;
        next_cycle();
        valid_i = 1'b0;
        @(negedge clk);
        chk("lb_stall_1", 64'(stall_o), 64'd1);
        next_cycle();
        @(negedge clk);
        chk("lb_stall_2", 64'(stall_o), 64'd1);
        next_cycle();
        resp_i = 1'b1; rdata_i = 32'h80FF_0000;
        @(negedge clk);
        chk("lb_stall_done", 64'(stall_o), 64'd0);
        chk("lb_load_regfile", 64'(load_regfile_o), 64'd1);
        chk("lb_rd_wr", 64'(rd_wr_o), 64'd7);
        chk("lb_wr_data", 64'(wr_data_o), 64'hFFFF_FF80);

        // LHU x3, upper half, response in first registered cycle
        next_cycle();
        resp_i = 1'b0;
        valid_i = 1'b1; ctrl_i = mk_ctrl(1'b1, 1'b1, RF_LHU); rd_i = 5'd3; alu_i = 32'h0000_0002;
        next_cycle();
        valid_i = 1'b0; resp_i = 1'b1; rdata_i = 32'hBEEF_1234;
        @(negedge clk);
        chk("lhu_stall", 64'(stall_o), 64'd0);
        chk("lhu_load_regfile", 64'(load_regfile_o), 64'd1);
        chk("lhu_wr_data", 64'(wr_data_o), 64'h0000_BEEF);

        // JAL x0: no write, still retires
        next_cycle();
        resp_i = 1'b0;
        valid_i = 1'b1; ctrl_i = mk_ctrl(1'b1, 1'b0, RF_PC_PLUS4); rd_i = 5'd0; pc_i = 32'h6000_0000;
        next_cycle();
        valid_i = 1'b0;
        @(negedge clk);
        chk("jal_x0_load_regfile", 64'(load_regfile_o), 64'd0);
        ir_before = m_instret;
        next_cycle();
        chk("jal_x0_instret_step", instret_o, ir_step == 64'd1 ? ir_before + 64'd1 : 64'd0);

        // JAL x1 at the top of the address space: pc+4 wraps
        valid_i = 1'b1; ctrl_i = mk_ctrl(1'b1, 1'b0, RF_PC_PLUS4); rd_i = 5'd1; pc_i = 32'hFFFF_FFFC;
        next_cycle();
        valid_i = 1'b0;
        @(negedge clk);
        chk("jal_wrap_load_regfile", 64'(load_regfile_o), 64'd1);
        chk("jal_wrap_wr_data", 64'(wr_data_o), 64'h0);

        // Reset while a load waits, then a late response must not write
        next_cycle();
        valid_i = 1'b1; ctrl_i = mk_ctrl(1'b1, 1'b1, RF_LW); rd_i = 5'd9; alu_i = 32'h0000_0040;
        next_cycle();
        valid_i = 1'b0;
        next_cycle();
        @(negedge clk);
        chk("wait_stall", 64'(stall_o), 64'd1);
        #1 rst = 1'b0;
        #1;
        chk("rst_wait_stall", 64'(stall_o), 64'd0);
        chk("rst_wait_load_regfile", 64'(load_regfile_o), 64'd0);
        chk("rst_wait_rd_wr", 64'(rd_wr_o), 64'd0);
        chk("rst_wait_wr_data", 64'(wr_data_o), 64'd0);
        next_cycle();
        next_cycle();
        rst = 1'b1; resp_i = 1'b1; rdata_i = 32'h1234_5678;
        @(negedge clk);
        chk("late_resp_load_regfile", 64'(load_regfile_o), 64'd0);
        chk("late_resp_stall", 64'(stall_o), 64'd0);
        next_cycle();
        @(negedge clk);
        chk("late_resp_load_regfile_2", 64'(load_regfile_o), 64'd0);

        // Randomized traffic with occasional resets
        for (int i = 0; i < 3000; i++) begin
            next_cycle();
            if (!rst) rst = 1'b1;
            else if ($urandom_range(399) == 0) rst = 1'b0;
            valid_i = ($urandom_range(9) < 7);
            flush_i = ($urandom_range(9) == 0);
            rsel    = regfilemux_sel_t'(4'($urandom_range(8)));
            ctrl_i  = mk_ctrl($urandom_range(3) != 0,
                              (rsel inside {RF_LW, RF_LB, RF_LBU, RF_LH, RF_LHU}) || ($urandom_range(9) == 0),
                              rsel);
            rd_i    = ($urandom_range(7) == 0) ? 5'd0 : 5'($urandom_range(31));
            alu_i   = $urandom;
            br_en_i = 1'($urandom_range(1));
            uimm_i  = $urandom & 32'hFFFF_F000;
            pc_i    = ($urandom_range(15) == 0) ? 32'hFFFF_FFFC : ($urandom & 32'hFFFF_FFFC);
            resp_i  = ($urandom_range(9) < 4);
            rdata_i = $urandom;
        end

        next_cycle();
        rst = 1'b1;
        idle_inputs();
        repeat (3) next_cycle();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
